// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between byte-stream requesters, the arbiter and the Uart8 tx port.
// master = requester/UART side, slave = arbiter side.
interface uart_tx_arbiter_if #(
    parameter int unsigned NUM_REQ = 4
);
    logic                   en;
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ*8-1:0]   req_data;
    logic [NUM_REQ-1:0]     req_last;
    logic [NUM_REQ-1:0]     req_ready;
    logic                   tx_en;
    logic [7:0]             tx_data;
    logic                   tx_valid;
    logic                   tx_ready;
    logic [NUM_REQ-1:0]     grant;
    logic                   busy;
    logic                   timeout_err;

    modport master (
        output en, req_valid, req_data, req_last, tx_ready,
        input  req_ready, tx_en, tx_data, tx_valid, grant, busy, timeout_err
    );

    modport slave (
        input  en, req_valid, req_data, req_last, tx_ready,
        output req_ready, tx_en, tx_data, tx_valid, grant, busy, timeout_err
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one Uart8 transmitter, with stall watchdog.
// Define UART_ARB_TAG_EN to prefix each packet with a 0xF0|id tag byte.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic             i_clk,
    input  logic             i_rst,
    uart_tx_arbiter_if.slave io_bus
);
    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned WD_W  = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_FIRE = WD_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
    localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT_CYCLES);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DATA = 2'd1;
`ifdef UART_ARB_TAG_EN
    localparam logic [1:0] ST_TAG  = 2'd2;
    localparam logic [1:0] ST_FIRST = ST_TAG;
`else
    localparam logic [1:0] ST_FIRST = ST_DATA;
`endif

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [IDX_W-1:0]   r_owner;
    logic [IDX_W-1:0]   r_last_grant;
    logic [IDX_W-1:0]   w_pick;
    logic [IDX_W-1:0]   w_cand;
    logic [NUM_REQ-1:0] r_grant;
    logic [WD_W-1:0]    r_wd;
    logic [7:0]         r_tx_data;
    logic [7:0]         w_tx_data;
    logic [7:0]         w_owner_data;
    logic               w_tx_valid;
    logic               w_owner_valid;
    logic               w_owner_last;
    logic               w_wd_fire;

    assign w_owner_valid = io_bus.req_valid[r_owner];
    assign w_owner_last  = io_bus.req_last[r_owner];
    assign w_owner_data  = io_bus.req_data[{r_owner, 3'b000} +: 8];

    always_comb begin
        w_pick = '0;
        w_cand = '0;
        // Walk downward so the requester nearest after last_grant is assigned last and wins.
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_cand = IDX_W'((32'(r_last_grant) + 32'(k)) % NUM_REQ);
            if (io_bus.req_valid[w_cand]) begin
                w_pick = w_cand;
            end
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_tx_valid       = 1'b0;
        w_tx_data        = r_tx_data;
        w_wd_fire        = 1'b0;
        io_bus.req_ready = '0;
        case (r_state)
            ST_IDLE: begin
                if (io_bus.en && (|io_bus.req_valid)) begin
                    w_state_nxt = ST_FIRST;
                end
            end
            ST_DATA: begin
                w_tx_valid = w_owner_valid;
                if (w_owner_valid) begin
                    w_tx_data = w_owner_data;
                end
                io_bus.req_ready[r_owner] = io_bus.tx_ready;
                if (w_owner_valid && io_bus.tx_ready && w_owner_last) begin
                    w_state_nxt = ST_IDLE;
                end else if (TIMEOUT_CYCLES != 0 && !w_owner_valid && r_wd == WD_FIRE) begin
                    w_wd_fire   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
`ifdef UART_ARB_TAG_EN
            ST_TAG: begin
                w_tx_valid = 1'b1;
                w_tx_data  = {4'hF, 4'(r_owner)};
                if (io_bus.tx_ready) begin
                    w_state_nxt = ST_DATA;
                end
            end
`endif
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_owner      <= '0;
            r_last_grant <= IDX_W'(NUM_REQ - 1);
            r_grant      <= '0;
            r_wd         <= '0;
            r_tx_data    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_tx_valid) begin
                r_tx_data <= w_tx_data;
            end
            if (r_state == ST_IDLE && w_state_nxt != ST_IDLE) begin
                r_owner <= w_pick;
                r_grant <= NUM_REQ'(1) << w_pick;
            end else if (r_state != ST_IDLE && w_state_nxt == ST_IDLE) begin
                r_last_grant <= r_owner;
                r_grant      <= '0;
            end
            // Stall counter runs only while the owner is silent mid-packet; saturates at the limit.
            if (r_state == ST_DATA && !w_owner_valid && w_state_nxt == ST_DATA) begin
                if (r_wd != WD_MAX) begin
                    r_wd <= r_wd + 1'b1;
                end
            end else begin
                r_wd <= '0;
            end
        end
    end

    assign io_bus.tx_valid    = w_tx_valid;
    assign io_bus.tx_data     = w_tx_data;
    assign io_bus.grant       = r_grant;
    assign io_bus.busy        = (r_state != ST_IDLE);
    assign io_bus.tx_en       = io_bus.en | (r_state != ST_IDLE);
    assign io_bus.timeout_err = w_wd_fire;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed + randomized bench for uart_tx_arbiter against a packet-level reference model.
module tb_uart_tx_arbiter;
    localparam int N  = 4;
    localparam int TO = 8;
`ifdef UART_ARB_TAG_EN
    localparam int FIRST_MODE = 2;
`else
    localparam int FIRST_MODE = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();

    uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model: mode 0 idle, 1 data, 2 tag; owner index, last winner, stalled-cycle count.
    int         m_mode, m_own, m_last, m_stall;
    logic [7:0] m_hold;

    logic [7:0]   tx_log[$];
    int           grant_log[$];
    logic [7:0]   pq[$];
    logic [7:0]   exp_q[$];
    logic [N-1:0] xfer;
    logic [N-1:0] prev_grant;
    logic         seen_to;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_own = 0; m_last = N - 1; m_stall = 0; m_hold = 8'h00;
        prev_grant = '0;
    endtask

    function automatic int pick();
        for (int k = 1; k <= N; k++) begin
            if (bus.req_valid[(m_last + k) % N]) return (m_last + k) % N;
        end
        return 0;
    endfunction

    task automatic cycle();
        logic [N-1:0] e_grant, e_ready;
        logic [7:0]   e_data;
        logic         e_valid, e_to, e_busy;
        int           nx_mode, nx_own, nx_last, nx_stall;
        @(negedge clk);
        e_busy  = (m_mode != 0);
        e_grant = e_busy ? (N'(1) << m_own) : '0;
        e_valid = (m_mode == 2) || (m_mode == 1 && bus.req_valid[m_own]);
        e_data  = m_hold;
        if (m_mode == 2) e_data = 8'hF0 | 8'(m_own);
        else if (e_valid) e_data = bus.req_data[8*m_own +: 8];
        e_ready = (m_mode == 1 && bus.tx_ready) ? (N'(1) << m_own) : '0;
        e_to    = (m_mode == 1) && !bus.req_valid[m_own] && (m_stall == TO - 1);
        chk("grant", 32'(bus.grant), 32'(e_grant));
        chk("busy", 32'(bus.busy), 32'(e_busy));
        chk("tx_valid", 32'(bus.tx_valid), 32'(e_valid));
        chk("tx_data", 32'(bus.tx_data), 32'(e_data));
        chk("req_ready", 32'(bus.req_ready), 32'(e_ready));
        chk("timeout_err", 32'(bus.timeout_err), 32'(e_to));
        chk("tx_en", 32'(bus.tx_en), 32'(bus.en | e_busy));
        xfer    = bus.req_valid & bus.req_ready;
        seen_to = bus.timeout_err;
        if (bus.tx_valid && bus.tx_ready) tx_log.push_back(bus.tx_data);
        if (bus.grant != '0 && prev_grant == '0) begin
            for (int i = 0; i < N; i++) if (bus.grant[i]) grant_log.push_back(i);
        end
        prev_grant = bus.grant;
        nx_mode = m_mode; nx_own = m_own; nx_last = m_last; nx_stall = m_stall;
        case (m_mode)
            0: if (bus.en && (|bus.req_valid)) begin
                nx_own = pick(); nx_mode = FIRST_MODE; nx_stall = 0;
            end
            2: if (bus.tx_ready) nx_mode = 1;
            default: begin
                if (bus.req_valid[m_own]) begin
                    nx_stall = 0;
                    if (bus.tx_ready && bus.req_last[m_own]) begin
                        nx_mode = 0; nx_last = m_own;
                    end
                end else if (e_to) begin
                    nx_mode = 0; nx_last = m_own; nx_stall = 0;
                end else begin
                    nx_stall = m_stall + 1;
                end
            end
        endcase
        @(posedge clk);
        m_mode = nx_mode; m_own = nx_own; m_last = nx_last; m_stall = nx_stall;
        if (e_valid) m_hold = e_data;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_grant", 32'(bus.grant), 0);
        chk("rst_req_ready", 32'(bus.req_ready), 0);
        chk("rst_tx_valid", 32'(bus.tx_valid), 0);
        chk("rst_tx_data", 32'(bus.tx_data), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_timeout", 32'(bus.timeout_err), 0);
        chk("rst_tx_en", 32'(bus.tx_en), 32'(bus.en));
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    // Sends the bytes in pq from requester r, advancing only on accepted transfers.
    task automatic run_pkt(input int r);
        int guard = 0;
        bus.req_valid[r] = 1'b1;
        while (pq.size() > 0 && guard < 200) begin
            bus.req_data[8*r +: 8] = pq[0];
            bus.req_last[r] = (pq.size() == 1);
            cycle();
            guard++;
            if (xfer[r]) void'(pq.pop_front());
        end
        chk("pkt_done", 32'(pq.size()), 0);
        bus.req_valid[r] = 1'b0;
        bus.req_last[r]  = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        bus.req_valid = '0;
        bus.req_last  = '0;
        bus.tx_ready  = 1'b1;
        do begin
            cycle();
            guard++;
        end while (bus.busy && guard < 40);
        chk("drain_idle", 32'(bus.busy), 0);
    endtask

    initial begin
        int guard;
        int stall_at;
        int to_cnt;
        bus.en = 1'b0; bus.req_valid = '0; bus.req_data = '0; bus.req_last = '0;
        bus.tx_ready = 1'b0;
        xfer = '0; seen_to = 1'b0;
        model_reset();
        do_reset();

        // Everyone always has a 1-byte packet: strict rotation starting at 0.
        bus.en = 1'b1; bus.tx_ready = 1'b1;
        bus.req_valid = '1; bus.req_last = '1; bus.req_data = 32'h13121110;
        grant_log.delete();
        guard = 0;
        while (grant_log.size() < 5 && guard < 40) begin cycle(); guard++; end
        chk("t1_g0", 32'(grant_log[0]), 0);
        chk("t1_g1", 32'(grant_log[1]), 1);
        chk("t1_g2", 32'(grant_log[2]), 2);
        chk("t1_g3", 32'(grant_log[3]), 3);
        chk("t1_g4", 32'(grant_log[4]), 0);
        drain();

        // Multi-byte packet from req0 is not interleaved with waiting req1.
        do_reset();
        tx_log.delete(); grant_log.delete();
        bus.req_valid[1] = 1'b1; bus.req_last[1] = 1'b1; bus.req_data[15:8] = 8'h77;
        pq = '{8'h11, 8'h22, 8'h33};
        run_pkt(0);
        bus.req_valid[1] = 1'b1; bus.req_last[1] = 1'b1;
        guard = 0;
        do begin cycle(); guard++; end while (!xfer[1] && guard < 20);
        bus.req_valid[1] = 1'b0;
`ifdef UART_ARB_TAG_EN
        exp_q = '{8'hF0, 8'h11, 8'h22, 8'h33, 8'hF1, 8'h77};
`else
        exp_q = '{8'h11, 8'h22, 8'h33, 8'h77};
`endif
        chk("t2_len", 32'(tx_log.size()), 32'(exp_q.size()));
        foreach (exp_q[i]) chk("t2_byte", 32'(tx_log[i]), 32'(exp_q[i]));
        chk("t2_gr0", 32'(grant_log[0]), 0);
        chk("t2_gr1", 32'(grant_log[1]), 1);
        drain();

        // Long downstream backpressure with the owner still valid: no watchdog.
        tx_log.delete();
        bus.req_valid[0] = 1'b1; bus.req_last[0] = 1'b0; bus.req_data[7:0] = 8'hA1;
        guard = 0;
        do begin cycle(); guard++; end while (!xfer[0] && guard < 20);
        bus.req_data[7:0] = 8'hA2; bus.tx_ready = 1'b0;
        to_cnt = 0;
        for (int i = 0; i < 50; i++) begin
            cycle();
            if (seen_to) to_cnt++;
            chk("t3_valid", 32'(bus.tx_valid), 1);
            chk("t3_data", 32'(bus.tx_data), 32'h A2);
        end
        chk("t3_no_timeout", 32'(to_cnt), 0);
        bus.tx_ready = 1'b1;
        pq = '{8'hA2, 8'hA3};
        run_pkt(0);
        chk("t3_tail", 32'(tx_log[tx_log.size()-1]), 32'hA3);
        drain();

        // Owner goes silent after one byte: release on the 8th stalled cycle, req2 next.
        grant_log.delete();
        bus.req_valid[0] = 1'b1; bus.req_last[0] = 1'b0; bus.req_data[7:0] = 8'hC1;
        guard = 0;
        do begin cycle(); guard++; end while (!xfer[0] && guard < 20);
        bus.req_valid[0] = 1'b0;
        bus.req_valid[2] = 1'b1; bus.req_last[2] = 1'b1; bus.req_data[23:16] = 8'hC2;
        stall_at = -1;
        for (int k = 1; k <= 12; k++) begin
            cycle();
            if (seen_to && stall_at < 0) stall_at = k;
        end
        chk("t4_timeout_cycle", 32'(stall_at), 8);
        chk("t4_first_owner", 32'(grant_log[0]), 0);
        chk("t4_next_owner", 32'(grant_log[1]), 2);
        drain();

        // Reset mid-packet, then requester 0 wins the first arbitration.
        bus.req_valid[1] = 1'b1; bus.req_last[1] = 1'b0; bus.req_data[15:8] = 8'hD1;
        guard = 0;
        do begin cycle(); guard++; end while (!xfer[1] && guard < 20);
        chk("t5_busy_before", 32'(bus.busy), 1);
        #2;
        bus.req_valid = '1; bus.req_last = '1;
        do_reset();
        grant_log.delete();
        guard = 0;
        while (grant_log.size() < 1 && guard < 10) begin cycle(); guard++; end
        chk("t5_first_after_rst", 32'(grant_log[0]), 0);
        drain();

        // Single-byte packet from req2 (tag-prefixed when the tag option is built in).
        tx_log.delete();
        pq = '{8'hAA};
        run_pkt(2);
`ifdef UART_ARB_TAG_EN
        exp_q = '{8'hF2, 8'hAA};
`else
        exp_q = '{8'hAA};
`endif
        chk("t6_len", 32'(tx_log.size()), 32'(exp_q.size()));
        foreach (exp_q[i]) chk("t6_byte", 32'(tx_log[i]), 32'(exp_q[i]));
        drain();

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            bus.en        = ($urandom_range(0, 9) != 0);
            bus.req_valid = N'($urandom);
            bus.req_last  = N'($urandom) & N'($urandom);
            bus.req_data  = $urandom;
            bus.tx_ready  = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
